// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: decoded control, operands, immediate and specifiers from ID, presented to EX one cycle later.
// Optional bubble counter output Bubble_Count_EX is compiled in when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall_ID_EX,
  input  logic              Flush_ID_EX,
  input  logic              Valid_ID,
  input  logic              RegWrite_ID,
  input  logic              MemtoReg_ID,
  input  logic              MemRead_ID,
  input  logic              MemWrite_ID,
  input  logic              Branch_ID,
  input  logic              RegDst_ID,
  input  logic              ALUSrc_ID,
  input  logic [1:0]        ALUOp_ID,
  input  logic [DATA_W-1:0] PC_Plus_4_ID,
  input  logic [DATA_W-1:0] Read_Data_1_ID,
  input  logic [DATA_W-1:0] Read_Data_2_ID,
  input  logic [DATA_W-1:0] Sign_Extend_Instruction_ID,
  input  logic [REG_W-1:0]  Rs_ID,
  input  logic [REG_W-1:0]  Rt_ID,
  input  logic [REG_W-1:0]  Rd_ID,
  output logic              Valid_EX,
  output logic              RegWrite_EX,
  output logic              MemtoReg_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              Branch_EX,
  output logic              RegDst_EX,
  output logic              ALUSrc_EX,
  output logic [1:0]        ALUOp_EX,
  output logic [DATA_W-1:0] PC_Plus_4_EX,
  output logic [DATA_W-1:0] Read_Data_1_EX,
  output logic [DATA_W-1:0] Read_Data_2_EX,
  output logic [DATA_W-1:0] Sign_Extend_Instruction_EX,
  output logic [REG_W-1:0]  Rs_EX,
  output logic [REG_W-1:0]  Rt_EX,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [REG_W-1:0]  Rd_EX,
  output logic [31:0]       Bubble_Count_EX
`else
  output logic [REG_W-1:0]  Rd_EX
`endif
);

  // Controls are gated by Valid_ID so an invalid slot can never write state downstream.
  always_ff @(posedge Clk) begin
    if (Reset || Flush_ID_EX) begin
      Valid_EX                   <= 1'b0;
      RegWrite_EX                <= 1'b0;
      MemtoReg_EX                <= 1'b0;
      MemRead_EX                 <= 1'b0;
      MemWrite_EX                <= 1'b0;
      Branch_EX                  <= 1'b0;
      RegDst_EX                  <= 1'b0;
      ALUSrc_EX                  <= 1'b0;
      ALUOp_EX                   <= 2'b00;
      PC_Plus_4_EX               <= '0;
      Read_Data_1_EX             <= '0;
      Read_Data_2_EX             <= '0;
      Sign_Extend_Instruction_EX <= '0;
      Rs_EX                      <= '0;
      Rt_EX                      <= '0;
      Rd_EX                      <= '0;
    end else if (!Stall_ID_EX) begin
      Valid_EX                   <= Valid_ID;
      RegWrite_EX                <= Valid_ID & RegWrite_ID;
      MemtoReg_EX                <= Valid_ID & MemtoReg_ID;
      MemRead_EX                 <= Valid_ID & MemRead_ID;
      MemWrite_EX                <= Valid_ID & MemWrite_ID;
      Branch_EX                  <= Valid_ID & Branch_ID;
      RegDst_EX                  <= Valid_ID & RegDst_ID;
      ALUSrc_EX                  <= Valid_ID & ALUSrc_ID;
      ALUOp_EX                   <= Valid_ID ? ALUOp_ID : 2'b00;
      PC_Plus_4_EX               <= PC_Plus_4_ID;
      Read_Data_1_EX             <= Read_Data_1_ID;
      Read_Data_2_EX             <= Read_Data_2_ID;
      Sign_Extend_Instruction_EX <= Sign_Extend_Instruction_ID;
      Rs_EX                      <= Rs_ID;
      Rt_EX                      <= Rt_ID;
      Rd_EX                      <= Rd_ID;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
  logic        bubble_in;

  // A bubble enters EX on a flush, or on a non-stalled load of an empty ID slot.
  assign bubble_in = Flush_ID_EX || (!Stall_ID_EX && !Valid_ID);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubble_cnt <= '0;
    end else if (bubble_in && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign Bubble_Count_EX = bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: behavioural next-state model, per-cycle compare, directed literal checks.
// Define ID_EX_BUBBLE_CNT_EN to also exercise the bubble counter.
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic        valid;
    logic [6:0]  ctl;     // RegWrite, MemtoReg, MemRead, MemWrite, Branch, RegDst, ALUSrc
    logic [1:0]  aluop;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } stage_t;

  logic   Clk = 1'b0;
  logic   Reset, Stall_ID_EX, Flush_ID_EX;
  stage_t id_in;
  stage_t ex_out;
  stage_t model;
  longint model_cnt;
  bit     chk_en = 0;
  int     checks = 0;
  int     errors = 0;

  logic Valid_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, RegDst_EX, ALUSrc_EX;
  logic [1:0]  ALUOp_EX;
  logic [31:0] PC_Plus_4_EX, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_Instruction_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] Bubble_Count_EX;
`endif

  always #5 Clk = ~Clk;

  id_ex_pipeline_reg #(.DATA_W(32), .REG_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Stall_ID_EX(Stall_ID_EX), .Flush_ID_EX(Flush_ID_EX),
    .Valid_ID(id_in.valid),
    .RegWrite_ID(id_in.ctl[6]), .MemtoReg_ID(id_in.ctl[5]), .MemRead_ID(id_in.ctl[4]),
    .MemWrite_ID(id_in.ctl[3]), .Branch_ID(id_in.ctl[2]), .RegDst_ID(id_in.ctl[1]),
    .ALUSrc_ID(id_in.ctl[0]), .ALUOp_ID(id_in.aluop),
    .PC_Plus_4_ID(id_in.pc), .Read_Data_1_ID(id_in.r1), .Read_Data_2_ID(id_in.r2),
    .Sign_Extend_Instruction_ID(id_in.imm),
    .Rs_ID(id_in.rs), .Rt_ID(id_in.rt), .Rd_ID(id_in.rd),
    .Valid_EX(Valid_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX),
    .RegDst_EX(RegDst_EX), .ALUSrc_EX(ALUSrc_EX), .ALUOp_EX(ALUOp_EX),
    .PC_Plus_4_EX(PC_Plus_4_EX), .Read_Data_1_EX(Read_Data_1_EX),
    .Read_Data_2_EX(Read_Data_2_EX), .Sign_Extend_Instruction_EX(Sign_Extend_Instruction_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
`ifdef ID_EX_BUBBLE_CNT_EN
    .Rd_EX(Rd_EX), .Bubble_Count_EX(Bubble_Count_EX)
`else
    .Rd_EX(Rd_EX)
`endif
  );

  assign ex_out = {Valid_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
                   RegDst_EX, ALUSrc_EX, ALUOp_EX, PC_Plus_4_EX, Read_Data_1_EX,
                   Read_Data_2_EX, Sign_Extend_Instruction_EX, Rs_EX, Rt_EX, Rd_EX};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stage_t rand_id();
    stage_t s;
    s.valid = ($urandom_range(0, 3) != 0);
    s.ctl   = 7'($urandom);
    s.aluop = 2'($urandom);
    s.pc    = $urandom;
    s.r1    = $urandom;
    s.r2    = $urandom;
    s.imm   = $urandom;
    s.rs    = 5'($urandom);
    s.rt    = 5'($urandom);
    s.rd    = 5'($urandom);
    return s;
  endfunction

  // What EX must hold after an edge, from the priority rules: reset/flush clear, stall holds,
  // otherwise take ID with the controls zeroed when the slot is empty.
  function automatic stage_t next_ex(input stage_t cur, input stage_t id, input logic rst,
                                     input logic fl, input logic st);
    stage_t n;
    if (rst || fl) return '0;
    if (st) return cur;
    n = id;
    if (!id.valid) begin
      n.ctl   = '0;
      n.aluop = '0;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge Clk);
    if (Reset) model_cnt = 0;
    else if (Flush_ID_EX || (!Stall_ID_EX && !id_in.valid))
      model_cnt = (model_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : model_cnt + 1;
    model = next_ex(model, id_in, Reset, Flush_ID_EX, Stall_ID_EX);
    #1;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      checks++;
      if (ex_out !== model) begin
        errors++;
        $display("FAIL ex_state: got %h expected %h", ex_out, model);
      end
      chk("bubble_invariant",
          64'(!Valid_EX && (RegWrite_EX || MemRead_EX || MemWrite_EX || Branch_EX)), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("bubble_count", 64'(Bubble_Count_EX), 64'(model_cnt));
`endif
    end
  end

  initial begin
    model = '0;
    model_cnt = 0;
    Reset = 1'b1; Stall_ID_EX = 1'b0; Flush_ID_EX = 1'b0;
    id_in = rand_id();

    // Reset for two edges with random ID inputs
    step();
    chk_en = 1;
    id_in = rand_id(); Stall_ID_EX = 1'($urandom);
    step();
    chk("rst_outputs", 64'(ex_out == '0), 64'd1);
    chk("rst_valid", 64'(Valid_EX), 64'd0);

    // Valid R-type load
    Reset = 1'b0; Stall_ID_EX = 1'b0; Flush_ID_EX = 1'b0;
    id_in = rand_id();
    id_in.valid = 1'b1; id_in.aluop = 2'b10; id_in.imm = 32'h20;
    id_in.r1 = 32'h1234; id_in.ctl[6] = 1'b1;
    step();
    chk("load_aluop", 64'(ALUOp_EX), 64'h2);
    chk("load_imm", 64'(Sign_Extend_Instruction_EX), 64'h20);
    chk("load_rd1", 64'(Read_Data_1_EX), 64'h1234);
    chk("load_regwrite", 64'(RegWrite_EX), 64'd1);
    chk("load_valid", 64'(Valid_EX), 64'd1);
    chk("model_pin_aluop", 64'(model.aluop), 64'h2);

    // Stall for three edges while ID changes
    Stall_ID_EX = 1'b1; id_in.aluop = 2'b00; id_in.imm = 32'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_aluop", 64'(ALUOp_EX), 64'h2);
      chk("stall_imm", 64'(Sign_Extend_Instruction_EX), 64'h20);
    end
    Stall_ID_EX = 1'b0;
    step();
    chk("unstall_aluop", 64'(ALUOp_EX), 64'h0);
    chk("unstall_imm", 64'(Sign_Extend_Instruction_EX), 64'h4);

    // Flush and stall together: flush wins
    Flush_ID_EX = 1'b1; Stall_ID_EX = 1'b1; id_in.valid = 1'b1; id_in.ctl[3] = 1'b1;
    step();
    chk("flush_outputs", 64'(ex_out == '0), 64'd1);
    chk("flush_valid", 64'(Valid_EX), 64'd0);
    chk("model_pin_bubbles", 64'(model_cnt), 64'd1);

    // Empty ID slot: controls zeroed, specifiers still load
    Flush_ID_EX = 1'b0; Stall_ID_EX = 1'b0;
    id_in = rand_id();
    id_in.valid = 1'b0; id_in.ctl[4] = 1'b1; id_in.aluop = 2'b01; id_in.rt = 5'd7;
    step();
    chk("invalid_memread", 64'(MemRead_EX), 64'd0);
    chk("invalid_aluop", 64'(ALUOp_EX), 64'h0);
    chk("invalid_valid", 64'(Valid_EX), 64'd0);
    chk("invalid_rt", 64'(Rt_EX), 64'd7);
    chk("model_pin_bubbles2", 64'(model_cnt), 64'd2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      Reset       = ($urandom_range(0, 24) == 0);
      Flush_ID_EX = ($urandom_range(0, 5) == 0);
      Stall_ID_EX = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 6) id_in = rand_id();
      else id_in.valid = 1'($urandom);
      step();
    end
    Reset = 1'b0; Flush_ID_EX = 1'b0; Stall_ID_EX = 1'b0;

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturation at the top of the counter
    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt;
    model_cnt = 64'hFFFF_FFFE;
    Flush_ID_EX = 1'b1;
    step();
    chk("sat_first", 64'(Bubble_Count_EX), 64'hFFFF_FFFF);
    step();
    chk("sat_hold", 64'(Bubble_Count_EX), 64'hFFFF_FFFF);
    Flush_ID_EX = 1'b0; Reset = 1'b1;
    step();
    chk("sat_reset", 64'(Bubble_Count_EX), 64'd0);
    Reset = 1'b0;
`endif

    step();
    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
